// File: rtl/qerv_rf_ram_arb.sv
// Register-file SRAM arbiter: core traffic always owns the RAM, and the host is admitted only outside the core window.
// Optional post-reset zeroing sequencer is enabled by defining QERV_RF_CLEAR_EN.
module qerv_rf_ram_arb #(
  parameter int width    = 8,
  parameter int csr_regs = 4,
  parameter int aw       = 5 + $clog2(32 + csr_regs) - $clog2(width),
  parameter int DEPTH    = (32 + csr_regs) * 32 / width,
  parameter int HOLD     = 40
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_core_rreq,
  input  logic             i_core_wreq,
  input  logic [aw-1:0]    i_core_waddr,
  input  logic [aw-1:0]    i_core_raddr,
  input  logic [width-1:0] i_core_wdata,
  input  logic             i_core_wen,
  input  logic             i_core_ren,
  output logic [width-1:0] o_core_rdata,
  input  logic             i_host_req,
  input  logic             i_host_we,
  input  logic [aw-1:0]    i_host_addr,
  input  logic [width-1:0] i_host_wdata,
  output logic [width-1:0] o_host_rdata,
  output logic             o_host_ack,
  output logic [aw-1:0]    o_waddr,
  output logic [aw-1:0]    o_raddr,
  output logic [width-1:0] o_wdata,
  output logic             o_wen,
  output logic             o_ren,
  input  logic [width-1:0] i_rdata,
  output logic             o_init_done,
  output logic             o_err
);

  localparam int HW = $clog2(HOLD + 1);

  typedef enum logic [1:0] {CLEAR, IDLE, RDWAIT, ACK} state_t;

  state_t           state_q, state_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [width-1:0] host_rdata_q, host_rdata_d;
  logic             core_req;
  logic             window_active;
  logic             host_issue;
  logic             init_done;

  assign core_req     = i_core_rreq | i_core_wreq;
  assign o_core_rdata = i_rdata;
  assign o_host_rdata = host_rdata_q;

`ifdef QERV_RF_CLEAR_EN
  localparam state_t RST_STATE = CLEAR;

  logic [aw-1:0] clr_addr_q, clr_addr_d;
  logic          init_done_q, init_done_d;
  logic          err_q, err_d;
  logic          clr_last;

  assign clr_last = (clr_addr_q == aw'(DEPTH - 1));

  always_comb begin
    clr_addr_d  = clr_addr_q;
    init_done_d = init_done_q;
    err_d       = err_q | (core_req & ~init_done_q);
    if (state_q == CLEAR) begin
      clr_addr_d = clr_addr_q + aw'(1);
      if (clr_last) begin
        init_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clr_addr_q  <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clr_addr_q  <= clr_addr_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end

  assign init_done = init_done_q;
  assign o_err     = err_q;
`else
  localparam state_t RST_STATE = IDLE;

  assign init_done = 1'b1;
  assign o_err     = 1'b0;
`endif

  assign o_init_done = init_done;

  // Core requests arriving before the RAM is ready are ignored and must not open a window.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (core_req & init_done) begin
      hold_cnt_d = HW'(HOLD);
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - HW'(1);
    end
  end

  assign window_active = (hold_cnt_q != '0) | core_req | i_core_ren | i_core_wen;
  assign host_issue    = (state_q == IDLE) & i_host_req & ~window_active & init_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= RST_STATE;
      hold_cnt_q   <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR: begin
`ifdef QERV_RF_CLEAR_EN
        if (clr_last) begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      IDLE: begin
        if (host_issue) begin
          state_d = i_host_we ? ACK : RDWAIT;
        end
      end
      RDWAIT:  state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = RST_STATE;
    endcase
  end

  always_comb begin
    o_waddr      = i_core_waddr;
    o_raddr      = i_core_raddr;
    o_wdata      = i_core_wdata;
    o_wen        = i_core_wen;
    o_ren        = i_core_ren;
    o_host_ack   = 1'b0;
    host_rdata_d = host_rdata_q;
    case (state_q)
      CLEAR: begin
`ifdef QERV_RF_CLEAR_EN
        // The sequencer owns the RAM; keep the write quiet while reset is held.
        o_wen   = ~i_rst;
        o_waddr = clr_addr_q;
        o_wdata = '0;
        o_ren   = 1'b0;
`endif
      end
      IDLE: begin
        if (host_issue) begin
          if (i_host_we) begin
            o_wen   = 1'b1;
            o_waddr = i_host_addr;
            o_wdata = i_host_wdata;
            o_ren   = 1'b0;
          end else begin
            o_ren   = 1'b1;
            o_raddr = i_host_addr;
            o_wen   = 1'b0;
          end
        end
      end
      RDWAIT:  host_rdata_d = i_rdata;
      ACK:     o_host_ack = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_qerv_rf_ram_arb.sv
// Directed bench for qerv_rf_ram_arb with a behavioural SRAM; the clear-sequencer steps run when QERV_RF_CLEAR_EN is defined.
`timescale 1ns/1ps
module tb_qerv_rf_ram_arb;
  localparam int W  = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_rreq, core_wreq, core_wen, core_ren;
  logic [AW-1:0] core_waddr, core_raddr;
  logic [W-1:0]  core_wdata, core_rdata;
  logic          host_req, host_we, host_ack;
  logic [AW-1:0] host_addr;
  logic [W-1:0]  host_wdata, host_rdata;
  logic [AW-1:0] waddr, raddr;
  logic [W-1:0]  wdata, rdata;
  logic          wen, ren, init_done, err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end

  qerv_rf_ram_arb dut (
    .i_clk(clk), .i_rst(rst),
    .i_core_rreq(core_rreq), .i_core_wreq(core_wreq),
    .i_core_waddr(core_waddr), .i_core_raddr(core_raddr),
    .i_core_wdata(core_wdata), .i_core_wen(core_wen), .i_core_ren(core_ren),
    .o_core_rdata(core_rdata),
    .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr),
    .i_host_wdata(host_wdata), .o_host_rdata(host_rdata), .o_host_ack(host_ack),
    .o_waddr(waddr), .o_raddr(raddr), .o_wdata(wdata), .o_wen(wen), .o_ren(ren),
    .i_rdata(rdata), .o_init_done(init_done), .o_err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    tick; host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d; #1;
    chk("hw_wen", wen, 1); chk("hw_waddr", waddr, a); chk("hw_wdata", wdata, d); chk("hw_ack0", host_ack, 0);
    tick; #1;
    chk("hw_ack", host_ack, 1); chk("hw_wen_off", wen, 0);
    $display("host write addr=%0h data=%0h", a, d);
    host_req = 1'b0;
    tick; #1;
    chk("hw_ack_end", host_ack, 0);
  endtask

  task automatic host_read(input logic [AW-1:0] a, input logic [W-1:0] exp);
    tick; host_req = 1'b1; host_we = 1'b0; host_addr = a; #1;
    chk("hr_ren", ren, 1); chk("hr_raddr", raddr, a); chk("hr_wen", wen, 0);
    tick; #1;
    chk("hr_ack_early", host_ack, 0);
    tick; #1;
    chk("hr_ack", host_ack, 1); chk("hr_rdata", host_rdata, exp);
    $display("host read addr=%0h data=%0h", a, host_rdata);
    host_req = 1'b0;
    tick; #1;
    chk("hr_ack_end", host_ack, 0); chk("hr_rdata_hold", host_rdata, exp);
  endtask

  initial begin
    rst = 1'b1;
    core_rreq = 0; core_wreq = 0; core_wen = 0; core_ren = 0;
    core_waddr = '0; core_raddr = '0; core_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    #12;
    chk("rst_wen", wen, 0); chk("rst_ren", ren, 0); chk("rst_ack", host_ack, 0);
    chk("rst_rdata", host_rdata, 0); chk("rst_err", err, 0); chk("rst_hold", dut.hold_cnt_q, 0);
`ifdef QERV_RF_CLEAR_EN
    chk("rst_init", init_done, 0);
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h05; host_wdata = 8'h77;
    tick; rst = 1'b0; #1;
    chk("clr_first_addr", waddr, 0); chk("clr_first_wen", wen, 1);
    for (int k = 1; k <= 70; k++) begin
      tick; core_rreq = (k == 10); #1;
      chk("clr_addr", waddr, k); chk("clr_wen", wen, 1);
      if (k == 11) chk("err_set", err, 1);
      if (k == 60) chk("err_sticky", err, 1);
    end
    rst = 1'b1; #1;
    chk("clr_rst_wen", wen, 0); chk("clr_rst_err", err, 0); chk("clr_rst_init", init_done, 0);
    tick; rst = 1'b0; #1;
    chk("clr_restart", waddr, 0);
    for (int k = 1; k < 144; k++) begin
      tick; #1;
      chk("clr2_addr", waddr, k); chk("clr2_wen", wen, 1); chk("clr2_wdata", wdata, 0);
      if (k == 143) chk("clr2_init", init_done, 0);
    end
    $display("clear sequence complete");
    tick; #1;
    chk("init_done", init_done, 1); chk("held_wen", wen, 1);
    chk("held_waddr", waddr, 8'h05); chk("held_wdata", wdata, 8'h77);
    tick; #1;
    chk("held_ack", host_ack, 1);
    host_req = 1'b0;
    tick; #1;
    chk("held_ack_end", host_ack, 0);
`else
    chk("rst_init", init_done, 1);
    tick; rst = 1'b0;
`endif
    host_write(8'h05, 8'hA5);
    host_read(8'h05, 8'hA5);
    host_write(8'hC8, 8'h3C);
    host_read(8'hC8, 8'h3C);

    // Core strobe coincides with a pending host read: core wins.
    tick; core_rreq = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05; #1;
    chk("arb_no_host_ren", ren, 0); chk("arb_no_host_wen", wen, 0);
    for (int c = 1; c <= 40; c++) begin
      logic exp_ren;
      exp_ren = (c < 20) && (c % 2 == 1);
      tick; core_rreq = 1'b0; core_ren = exp_ren; core_raddr = AW'(c); #1;
      if (c == 1) chk("arb_hold40", dut.hold_cnt_q, 40);
      chk("arb_ren", ren, exp_ren);
      if (exp_ren) chk("arb_raddr", raddr, c);
      chk("arb_ack", host_ack, 0);
    end
    tick; core_ren = 1'b0; #1;
    chk("arb_issue_ren", ren, 1); chk("arb_issue_raddr", raddr, 8'h05); chk("arb_hold0", dut.hold_cnt_q, 0);
    tick; #1;
    chk("arb_ack_early", host_ack, 0);
    tick; #1;
    chk("arb_ack", host_ack, 1); chk("arb_rdata", host_rdata, 8'hA5);
    $display("arbitrated host read data=%0h", host_rdata);
    host_req = 1'b0;

    tick; core_wen = 1'b1; core_waddr = 8'h22; core_wdata = 8'h5A; #1;
    chk("core_wen", wen, 1); chk("core_waddr", waddr, 8'h22); chk("core_wdata", wdata, 8'h5A);
    tick; core_wen = 1'b0;

    // Reset while the host read sits in RDWAIT drops the ack.
    tick; host_req = 1'b1; host_we = 1'b0; host_addr = 8'hC8; #1;
    chk("rdw_issue", ren, 1);
    tick; #1;
    rst = 1'b1; #1;
    chk("rdw_rdata_rst", host_rdata, 0); chk("rdw_ack_rst", host_ack, 0);
    host_req = 1'b0; #2;
    rst = 1'b0;
    tick; #1;
    chk("rdw_ack1", host_ack, 0);
    tick; #1;
    chk("rdw_ack2", host_ack, 0);
    $display("reset during read: no ack");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/qerv_rf_ram_arb.md
# qerv_rf_ram_arb

Shares the register-file SRAM between the core's RF RAM interface and a host word-access port (debug/loader). Sits between the RF RAM interface's RAM-side ports and the SRAM macro. Core traffic always wins and is never stalled: the host is admitted only outside a guarded core window. An optional post-reset sequencer zeroes the whole RAM before the core may run.

## Interface
- `width`, 8: SRAM data width; must match the RF RAM interface.
- `csr_regs`, 4: CSR registers stored after the 32 GPRs.
- `aw`, `5+$clog2(32+csr_regs)-$clog2(width)`: RAM address width (derived; do not override).
- `DEPTH`, `(32+csr_regs)*32/width`: used words, addresses 0..DEPTH-1 (derived).
- `HOLD`, 40: core-window length in cycles after a core request.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `i_core_rreq`, `i_core_wreq`  in  1  core RF read/write request strobes, tapped from core.
- `i_core_waddr`, `i_core_raddr`  in  aw  core RAM addresses.
- `i_core_wdata`  in  width  core write data.
- `i_core_wen`, `i_core_ren`  in  1  core RAM enables.
- `o_core_rdata`  out  width  = `i_rdata`, unregistered.
- `i_host_req`  in  1  host request; held until ack.
- `i_host_we`  in  1  1=write, 0=read; stable while req.
- `i_host_addr`  in  aw  host word address.
- `i_host_wdata`  in  width  host write data.
- `o_host_rdata`  out  width  registered read data.
- `o_host_ack`  out  1  one-cycle completion pulse.
- `o_waddr`, `o_raddr`  out  aw  SRAM addresses.
- `o_wdata`  out  width  SRAM write data.
- `o_wen`, `o_ren`  out  1  SRAM enables.
- `i_rdata`  in  width  SRAM read data; valid one cycle after `o_ren`.
- `o_init_done`  out  1  RAM ready for the core.
- `o_err`  out  1  sticky: core request seen while `o_init_done`=0.

## Operation
- FSM states: CLEAR, IDLE, RDWAIT, ACK.
- Reset state is CLEAR if the macro is defined, otherwise IDLE.
- Window counter `hold_cnt`:
  - Loads HOLD on `i_core_rreq|i_core_wreq`; otherwise decrements to 0 and saturates.
  - Window active = `hold_cnt!=0 | i_core_rreq | i_core_wreq | i_core_ren | i_core_wen`.
- RAM mux:
  - CLEAR state: sequencer drives the RAM.
  - Else, core ports drive the RAM whenever the host is not issuing.
  - Host issue cycle: `o_*` take host values and the core enables must be 0 (guaranteed by the window).
- IDLE, `i_host_req` and window inactive: issue the access this cycle.
  - Write: `o_wen`=1, `o_waddr`=addr, `o_wdata`=wdata; go to ACK.
  - Read: `o_ren`=1, `o_raddr`=addr; go to RDWAIT.
- RDWAIT: capture `i_rdata` into `o_host_rdata`; go to ACK.
- ACK: `o_host_ack`=1 for one cycle; go to IDLE.
  - The host deasserts or changes `i_host_req` at this edge.
  - `i_host_req` sampled in ACK is ignored.
- Host address >= DEPTH: access is performed anyway (no range check).
- Core request in the same cycle as a pending host req: host waits; no host issue that cycle.
- `o_err`: set when `i_core_rreq|i_core_wreq` while `o_init_done`=0; cleared only by reset.
  - The core request is otherwise ignored.
  - RAM stays with the sequencer.

## Timing
- Reset values: `o_ren`=`o_wen`=0, `o_host_ack`=0, `o_host_rdata`=0, `o_err`=0, `hold_cnt`=0, clear address=0.
  - `o_init_done`=0 with the macro, 1 without.
- Host write latency: issue cycle A, ack at A+1.
- Host read latency: issue A, data captured end of A+1, ack and valid `o_host_rdata` at A+2.
- `o_host_rdata` holds until the next read completes.
- Minimum host admission: HOLD+1 cycles after the last core request strobe.
- Async reset mid-read or mid-clear:
  - Pending ack is dropped.
  - Clear restarts from address 0.

## Configuration
- `QERV_RF_CLEAR_EN` defined:
  - After reset, CLEAR writes 0 to addresses 0..DEPTH-1, one per cycle (`o_wen`=1, `o_wdata`=0).
  - Then `o_init_done` rises the cycle after the last write, and the FSM enters IDLE.
  - Host requests wait until then.
- Not defined:
  - No sequencer logic; `o_init_done` is tied 1 and `o_err` tied 0.
  - The FSM starts in IDLE.

## Test plan
- Clear, width=8, csr_regs=4, macro on: reset release → 144 consecutive `o_wen` cycles at addresses 0..143 with data 0x00, then `o_init_done`=1; host req held throughout is served after.
- Host write then read, window idle: write addr 0x05 data 0xA5 → ack at A+1; read 0x05 → `o_ren` at B, ack at B+2 with `o_host_rdata`=0xA5.
- Host vs core, HOLD=40:
  - `i_core_rreq` at cycle 0 with host read pending → host issues no earlier than cycle 41.
  - Core `o_ren` pattern passes through unchanged.
- Simultaneous core request and host req in IDLE with the window otherwise expired → core request wins, no host enable that cycle, `hold_cnt`=40 next cycle.
- Core request during clear → `o_err`=1 and sticky; clear sequence uninterrupted; `o_err` clears only on reset.
- Async reset asserted in RDWAIT (and, separately, at clear address 70) → no ack issued; clear restarts at address 0 after release.
